// File: rtl/snn_debug_pkg.sv
// rtl/snn_debug_pkg.sv - shared encodings for the SNN debug probe
package snn_debug_pkg;

  // Debug bus modes held in config[5:4]
  localparam logic [1:0] MODE_LIVE    = 2'd0;
  localparam logic [1:0] MODE_CAPTURE = 2'd1;
  localparam logic [1:0] MODE_READ    = 2'd2;
  localparam logic [1:0] MODE_COUNT   = 2'd3;

  // Config register layout
  localparam int CFG_W        = 8;
  localparam int SEL_LSB      = 0;
  localparam int SEL_W        = 4;
  localparam int MODE_LSB     = 4;
  localparam int MODE_W       = 2;
  localparam int TRIG_IMM_BIT = 6;

  // Capture FSM
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_CAPTURING = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

endpackage

// File: rtl/snn_debug_capture_buf.sv
// rtl/snn_debug_capture_buf.sv - DEPTH x OUT_W capture store with write and read pointers
module snn_debug_capture_buf #(
  parameter int DEPTH = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [OUT_W-1:0] wr_data_i,
  input  logic             rd_adv_i,
  output logic [OUT_W-1:0] rd_data_o,
  output logic             wr_last_o
);

  localparam int AW = $clog2(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

  // Pointer next-state: clear dominates; both pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_i)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv_i) rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Storage and pointer registers; contents survive a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_last_o = (wr_ptr_q == AW'(DEPTH - 1));

endmodule

// File: rtl/snn_debug_probe.sv
// rtl/snn_debug_probe.sv - debug bus mux, triggered capture, readback and spike counter
module snn_debug_probe
  import snn_debug_pkg::*;
#(
  parameter int N_NEURONS = 10,
  parameter int MP_W      = 6,
  parameter int N_SPIKES  = 8,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CFG_W-1:0]          debug_config_in,
  input  logic                      rd_en,
  input  logic [N_NEURONS*MP_W-1:0] membrane_potentials,
  input  logic [N_SPIKES-1:0]       output_spikes_layer1,
  output logic [OUT_W-1:0]          debug_output,
  output logic                      capture_busy,
  output logic                      capture_done
);

  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [OUT_W-1:0]  cnt_q, cnt_d;
  cap_state_e        state_q, state_d;

  logic [SEL_W-1:0]  sel;
  logic [MODE_W-1:0] mode;
  logic [MODE_W-1:0] new_mode;
  logic              trig_imm;
  logic              unused_cfg_reserved;

  logic [MP_W-1:0]   mp_sel;
  logic [OUT_W-1:0]  mp_ext;
  logic [OUT_W-1:0]  spk_ext;
  logic [OUT_W-1:0]  chan_val;
  logic              cnt_bit;
  logic              trig;

  logic              buf_clear, buf_wr, buf_adv, buf_wr_last;
  logic [OUT_W-1:0]  buf_rd_data;

  assign sel                 = cfg_q[SEL_LSB +: SEL_W];
  assign mode                = cfg_q[MODE_LSB +: MODE_W];
  assign trig_imm            = cfg_q[TRIG_IMM_BIT];
  assign new_mode            = debug_config_in[MODE_LSB +: MODE_W];
  assign unused_cfg_reserved = cfg_q[CFG_W-1];

  // Pick the selected membrane potential and the counted spike bit
  always_comb begin
    mp_sel  = '0;
    cnt_bit = 1'b0;
    for (int i = 0; i < N_NEURONS; i++)
      if (int'(sel) == i) mp_sel = membrane_potentials[i*MP_W +: MP_W];
    for (int i = 0; i < N_SPIKES; i++)
      if ((int'(sel) % N_SPIKES) == i) cnt_bit = output_spikes_layer1[i];
  end

  // Wide potentials keep their MSBs; narrow ones are zero-extended
  if (MP_W > OUT_W) begin : g_mp_msb
    assign mp_ext = mp_sel[MP_W-1 -: OUT_W];
  end else begin : g_mp_zext
    assign mp_ext = OUT_W'(mp_sel);
  end

  assign spk_ext  = OUT_W'(output_spikes_layer1);
  assign chan_val = (int'(sel) < N_NEURONS) ? mp_ext : spk_ext;
  assign trig     = trig_imm | (|output_spikes_layer1);

  // Capture FSM next state and buffer controls; a config write always restarts
  always_comb begin
    state_d   = state_q;
    buf_clear = 1'b0;
    buf_wr    = 1'b0;
    buf_adv   = 1'b0;
    if (en) begin
      buf_clear = 1'b1;
      if (new_mode == MODE_CAPTURE)
        state_d = ST_ARMED;
      else if (new_mode == MODE_READ && state_q == ST_DONE)
        state_d = ST_DONE;
      else
        state_d = ST_IDLE;
    end else begin
      buf_adv = (mode == MODE_READ) && rd_en;
      case (state_q)
        ST_ARMED: begin
          if (trig) begin
            buf_wr  = 1'b1;
            state_d = ST_CAPTURING;
          end
        end
        ST_CAPTURING: begin
          buf_wr = 1'b1;
          if (buf_wr_last) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Config, saturating counter and debug bus next values
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    if (en) begin
      cfg_d = debug_config_in;
      cnt_d = '0;
    end else if (mode == MODE_COUNT && cnt_bit && cnt_q != '1) begin
      cnt_d = cnt_q + OUT_W'(1);
    end
    case (mode)
      MODE_READ:  out_d = buf_rd_data;
      MODE_COUNT: out_d = cnt_q;
      default:    out_d = chan_val;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

  snn_debug_capture_buf #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (buf_clear),
    .wr_en_i   (buf_wr),
    .wr_data_i (chan_val),
    .rd_adv_i  (buf_adv),
    .rd_data_o (buf_rd_data),
    .wr_last_o (buf_wr_last)
  );

  assign debug_output = out_q;
  assign capture_busy = (state_q == ST_ARMED) || (state_q == ST_CAPTURING);
  assign capture_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_snn_debug_probe.sv
// tb/tb_snn_debug_probe.sv - self-checking bench for snn_debug_probe
module tb_snn_debug_probe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  cfg_in = 8'h00;
  logic        rd_en = 1'b0;
  logic [5:0]  pot [10];
  logic [59:0] mp_flat;
  logic [7:0]  spikes = 8'h00;
  logic [7:0]  debug_output;
  logic        capture_busy;
  logic        capture_done;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: 0 idle, 1 armed, 2 capturing, 3 done
  int m_cfg = 0, m_state = 0, m_wr = 0, m_rd = 0, m_cnt = 0, m_out = 0;
  int m_buf [16];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 10; i++) mp_flat[i*6 +: 6] = pot[i];
  end

  snn_debug_probe dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .debug_config_in      (cfg_in),
    .rd_en                (rd_en),
    .membrane_potentials  (mp_flat),
    .output_spikes_layer1 (spikes),
    .debug_output         (debug_output),
    .capture_busy         (capture_busy),
    .capture_done         (capture_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the probe, stepped on each rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cfg = 0; m_state = 0; m_wr = 0; m_rd = 0; m_cnt = 0; m_out = 0;
      for (int i = 0; i < 16; i++) m_buf[i] = 0;
    end else begin
      int sel, mode, ch, nmode;
      sel  = m_cfg % 16;
      mode = (m_cfg / 16) % 4;
      ch   = (sel < 10) ? int'(pot[sel]) : int'(spikes);
      if (mode == 2)      m_out = m_buf[m_rd];
      else if (mode == 3) m_out = m_cnt;
      else                m_out = ch;
      if (en) begin
        nmode = (int'(cfg_in) / 16) % 4;
        m_cfg = int'(cfg_in);
        m_wr = 0; m_rd = 0; m_cnt = 0;
        if (nmode == 1)                       m_state = 1;
        else if (nmode == 2 && m_state == 3)  m_state = 3;
        else                                  m_state = 0;
      end else begin
        if (mode == 3 && spikes[sel % 8] && m_cnt < 255) m_cnt = m_cnt + 1;
        if (mode == 2 && rd_en) m_rd = (m_rd + 1) % 16;
        if (m_state == 1 && (((m_cfg / 64) % 2 == 1) || spikes != 0)) begin
          m_buf[0] = ch; m_wr = 1; m_state = 2;
        end else if (m_state == 2) begin
          m_buf[m_wr] = ch;
          if (m_wr == 15) begin m_state = 3; m_wr = 0; end
          else m_wr = m_wr + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out",  debug_output, m_out);
      chk("model_busy", capture_busy, (m_state == 1 || m_state == 2));
      chk("model_done", capture_done, (m_state == 3));
    end
  end

  task automatic cfg_write(input logic [7:0] v, input logic rd);
    @(negedge clk);
    en = 1'b1; cfg_in = v; rd_en = rd;
    @(negedge clk);
    en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) pot[i] = 6'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_out",  debug_output, 8'h00);
    chk("reset_busy", capture_busy, 1'b0);
    chk("reset_done", capture_done, 1'b0);
    rst_n = 1'b1;

    // 1: live potential[3]
    pot[3] = 6'h2A;
    cfg_write(8'h03, 1'b0);
    @(negedge clk);
    chk("live_pot3", debug_output, 8'h2A);

    // 2: sel beyond neurons shows spikes
    spikes = 8'hA5;
    cfg_write(8'h0C, 1'b0);
    @(negedge clk);
    chk("live_spikes", debug_output, 8'hA5);
    spikes = 8'h00;

    // 3: capture on spike, ramping potential[1]
    pot[1] = 6'd0;
    cfg_write(8'h11, 1'b0);
    chk("armed_busy", capture_busy, 1'b1);
    for (int v = 0; v <= 25; v++) begin
      pot[1] = 6'(v);
      spikes = (v == 5) ? 8'h10 : 8'h00;
      @(negedge clk);
      if (v == 10) chk("capturing_busy", capture_busy, 1'b1);
    end
    chk("cap_done", capture_done, 1'b1);
    chk("cap_not_busy", capture_busy, 1'b0);

    cfg_write(8'h21, 1'b0);
    @(negedge clk);
    chk("read_entry0", debug_output, 8'd5);
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      chk($sformatf("read_entry_%0d", i % 16), debug_output, 8'(5 + (i % 16)));
    end
    chk("done_persists", capture_done, 1'b1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    cfg_write(8'h21, 1'b1);
    @(negedge clk);
    chk("en_beats_rd_en", debug_output, 8'd5);

    // 4: immediate trigger, then abort
    pot[1] = 6'd50;
    cfg_write(8'h51, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("imm_busy", capture_busy, 1'b1);
    cfg_write(8'h00, 1'b0);
    chk("abort_busy", capture_busy, 1'b0);
    chk("abort_done", capture_done, 1'b0);
    pot[1] = 6'd33;
    cfg_write(8'h51, 1'b0);
    repeat (20) @(negedge clk);
    chk("imm_done", capture_done, 1'b1);
    cfg_write(8'h21, 1'b0);
    @(negedge clk);
    chk("imm_entry0", debug_output, 8'd33);

    // 5: saturating spike counter on bit 2
    spikes = 8'h04;
    cfg_write(8'h32, 1'b0);
    @(negedge clk);
    chk("cnt_start", debug_output, 8'd0);
    @(negedge clk);
    chk("cnt_one", debug_output, 8'd1);
    repeat (300) @(negedge clk);
    chk("cnt_sat", debug_output, 8'hFF);
    cfg_write(8'h32, 1'b0);
    @(negedge clk);
    chk("cnt_clear", debug_output, 8'h00);
    spikes = 8'h00;

    // 6: asynchronous reset during capture
    pot[1] = 6'd7;
    cfg_write(8'h51, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", capture_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out",  debug_output, 8'h00);
    chk("rst_busy", capture_busy, 1'b0);
    chk("rst_done", capture_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pot[0] = 6'h15;
    cfg_write(8'h00, 1'b0);
    @(negedge clk);
    chk("post_reset_pot0", debug_output, 8'h15);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
